mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single-port 32x8 program/data memory of the RISC core. It shares the memory between the CPU datapath (controller rd/wr, mux address, driver data) and an external DMA/loader port, serving exactly one owner per cycle. The CPU has priority by default. A starvation counter forces a DMA slot and stalls the CPU (the stall freezes the phase generator) when the DMA has been denied too long. It sits between the CPU control/address/data nets and the memory instance at the top level.

## Interface
- AWIDTH, 5: memory address width.
- DWIDTH, 8: memory data width.
- MAX_WAIT, 4: consecutive denied DMA cycles before a forced DMA slot; legal range 1..15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cpu_rd  in  1  CPU read request (controller rd).
- cpu_wr  in  1  CPU write request (controller wr).
- cpu_addr  in  AWIDTH  CPU address (mux output).
- cpu_wdata  in  DWIDTH  CPU write data (accumulator/ALU path).
- cpu_stall  out  1  CPU must hold its phase and request this cycle.
- dma_req  in  1  DMA access request; held until granted.
- dma_we  in  1  1 = write, 0 = read; stable while dma_req is high.
- dma_addr  in  AWIDTH  DMA address; stable while dma_req is high.
- dma_wdata  in  DWIDTH  DMA write data; stable while dma_req is high.
- dma_gnt  out  1  DMA owns memory this cycle; the access completes at this cycle's edge.
- dma_rvalid  out  1  one-cycle pulse: dma_rdata holds the result of a granted read.
- dma_rdata  out  DWIDTH  registered read data.
- mem_rd, mem_wr  out  1  memory strobes.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data, combinational from mem_addr while mem_rd is high.

## Operation
- cpu_act = cpu_rd | cpu_wr.
- force = (wait_cnt == MAX_WAIT).
- Ownership is decided combinationally each cycle, in priority order:
  - rst: no owner; mem_rd = mem_wr = 0; dma_gnt = 0; cpu_stall = 0.
  - force & dma_req: DMA owns; cpu_stall = cpu_act.
  - cpu_act: CPU owns; mem_* = cpu_*; dma_gnt = 0; cpu_stall = 0.
  - dma_req: DMA owns; cpu_stall = 0.
  - Otherwise idle: all strobes 0; mem_addr/mem_wdata = 0.
- When DMA owns: dma_gnt = 1; mem_rd = ~dma_we; mem_wr = dma_we; mem_addr = dma_addr; mem_wdata = dma_wdata.
- Never assert mem_rd and mem_wr together. If the CPU asserts both, pass them through unchanged: that is a controller error and the bench flags it.
- wait_cnt (4 bits), updated at each edge:
  - rst -> 0.
  - dma_gnt -> 0.
  - dma_req & ~dma_gnt -> wait_cnt + 1, saturating at MAX_WAIT.
  - ~dma_req -> 0.
- dma_rdata / dma_rvalid:
  - At the edge of a granted DMA read, dma_rdata <= mem_rdata and dma_rvalid <= 1.
  - Otherwise dma_rvalid <= 0 and dma_rdata holds.
- Stalled CPU: the phase generator is frozen, so cpu_* are unchanged next cycle. force is then 0, so the CPU is served.
- DMA protocol: the master may drop dma_req only after the edge where dma_gnt = 1. An early drop clears wait_cnt and causes no memory access.

## Timing
- Reset values: cpu_stall 0, dma_gnt 0, dma_rvalid 0, dma_rdata 0, mem_rd 0, mem_wr 0, mem_addr 0, mem_wdata 0, wait_cnt 0.
- Grant latency:
  - Idle memory: 0 cycles (dma_gnt in the same cycle as dma_req).
  - Continuous CPU traffic: exactly MAX_WAIT cycles of denial, then a grant on cycle MAX_WAIT (counting from 0).
- Write: memory captures on the edge ending the grant cycle.
- Read: dma_rvalid/dma_rdata appear 1 cycle after the grant cycle.
- Back-to-back DMA: a new request may be presented in the cycle after a grant. With the CPU idle, the sustained rate is one access per cycle.
- Each forced slot costs the CPU exactly one stall cycle. Starvation bound: every MAX_WAIT+1 cycles.
- Reset mid-operation: a DMA grant coinciding with rst produces no memory write and no dma_rvalid. The master must re-issue after reset.
- Simultaneous events:
  - CPU and DMA in the same cycle with force = 0: CPU wins.
  - force = 1 and the CPU is idle: DMA is granted, no stall.

## Test plan
- Idle CPU, DMA write 0xA5 to 0x03, then read 0x03 -> gnt in the same cycle each time; the read yields dma_rvalid pulse with dma_rdata = 0xA5 one cycle later.
- CPU rd every cycle, dma_req held from cycle 0, MAX_WAIT = 4 -> dma_gnt = 0 on cycles 0-3; cycle 4 dma_gnt = 1 and cpu_stall = 1; cycle 5 CPU served and wait_cnt = 0.
- CPU wr 0x3C to 0x1F and DMA req on the same cycle with wait_cnt = 0 -> mem_wr with addr 0x1F, data 0x3C; dma_gnt = 0; wait_cnt = 1.
- Alternating CPU busy/idle cycles with DMA reads of 0x00..0x07 -> each DMA read is granted on the first idle cycle; no cpu_stall ever; 8 dma_rvalid pulses with correct data.
- rst asserted during a DMA write grant to 0x10 (prior contents 0x11) -> memory still reads 0x11; all outputs 0 in the cycle after reset.
- MAX_WAIT = 1, CPU always active, DMA always requesting -> grants alternate CPU/DMA each cycle; cpu_stall high on every DMA slot.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the core's single-port program/data memory.
// CPU wins by default; a starved DMA request forces one slot and stalls the CPU.
module mem_arbiter #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AWIDTH-1:0] dma_addr,
  input  logic [DWIDTH-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DWIDTH-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       cpu_act;
  logic       force_slot;
  logic       dma_own;
  logic       cpu_own;
  logic       dma_rd_done;

  assign cpu_act    = cpu_rd | cpu_wr;
  assign force_slot = (wait_cnt == WAIT_LIMIT);

  always_comb begin
    dma_own   = 1'b0;
    cpu_own   = 1'b0;
    cpu_stall = 1'b0;
    if (!rst) begin
      if (force_slot && dma_req) begin
        dma_own   = 1'b1;
        cpu_stall = cpu_act;
      end else if (cpu_act) begin
        cpu_own = 1'b1;
      end else if (dma_req) begin
        dma_own = 1'b1;
      end
    end
  end

  // A CPU that raises rd and wr together is passed through untouched so the
  // controller fault stays visible on the memory strobes.
  always_comb begin
    dma_gnt   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dma_own) begin
      dma_gnt   = 1'b1;
      mem_rd    = ~dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_own) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign dma_rd_done = dma_gnt & ~dma_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= 4'd0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      if (dma_gnt || !dma_req) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      dma_rvalid <= dma_rd_done;
      if (dma_rd_done) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table plus directed starvation sequences.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_rd, cpu_wr;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       dma_req, dma_we;
  logic [4:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       mem_load;

  logic       cpu_stall, dma_gnt, dma_rvalid, mem_rd, mem_wr;
  logic [7:0] dma_rdata, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;

  logic       cpu_stall1, dma_gnt1, dma_rvalid1, mem_rd1, mem_wr1;
  logic [7:0] dma_rdata1, mem_wdata1;
  logic [4:0] mem_addr1;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_WAIT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt1), .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(8'h00)
  );

  // 32x8 memory model: combinational read while mem_rd, write on the edge
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 16) ? 8'h11 : 8'(8'h80 + i);
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

  typedef struct {
    logic       rst, crd, cwr;
    logic [4:0] ca;
    logic [7:0] cwd;
    logic       dreq, dwe;
    logic [4:0] da;
    logic [7:0] dw;
    logic       gnt, stall, mrd, mwr;
    logic [4:0] ma;
    logic [7:0] mwd;
    logic       rv;
    logic [7:0] rd;
    logic       rdchk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, crd, cwr, input logic [4:0] ca, input logic [7:0] cwd,
                     input logic dreq, dwe, input logic [4:0] da, input logic [7:0] dw,
                     input logic gnt, stall, mrd, mwr, input logic [4:0] ma,
                     input logic [7:0] mwd, input logic rv, input logic [7:0] rd,
                     input logic rdchk);
    vec_t v;
    v.rst = r; v.crd = crd; v.cwr = cwr; v.ca = ca; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.da = da; v.dw = dw;
    v.gnt = gnt; v.stall = stall; v.mrd = mrd; v.mwr = mwr; v.ma = ma; v.mwd = mwd;
    v.rv = rv; v.rd = rd; v.rdchk = rdchk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge; sample before the rising edge.
  task automatic drive(input logic r, crd, cwr, input logic [4:0] ca, input logic [7:0] cwd,
                       input logic dreq, dwe, input logic [4:0] da, input logic [7:0] dw);
    @(negedge clk);
    rst = r; cpu_rd = crd; cpu_wr = cwr; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wdata = dw;
    #3;
    chk("strobe exclusivity", 32'(mem_rd & mem_wr), 32'(crd & cwr & ~dma_gnt));
  endtask

  function automatic logic [7:0] memval(input int k);
    return (k == 3) ? 8'hA5 : 8'(8'h80 + k);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_load = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

    // reset
    add(1,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 0,8'h00,1);
    // idle CPU: DMA write A5 -> 03, read 03
    add(0,0,0,5'h00,8'h00, 1,1,5'h03,8'hA5, 1,0,0,1,5'h03,8'hA5, 0,8'h00,0);
    add(0,0,0,5'h00,8'h00, 1,0,5'h03,8'h00, 1,0,1,0,5'h03,8'h00, 0,8'h00,0);
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 1,8'hA5,1);
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 0,8'hA5,1);
    // CPU read every cycle, DMA read 07 held: four denials, then forced slot
    for (int c = 0; c < 4; c++)
      add(0,1,0,5'h05,8'h00, 1,0,5'h07,8'h00, 0,0,1,0,5'h05,8'h00, 0,8'h00,0);
    add(0,1,0,5'h05,8'h00, 1,0,5'h07,8'h00, 1,1,1,0,5'h07,8'h00, 0,8'h00,0);
    add(0,1,0,5'h05,8'h00, 0,0,5'h00,8'h00, 0,0,1,0,5'h05,8'h00, 1,8'h87,1);
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 0,8'h00,0);
    // CPU write 3C -> 1F wins against a fresh DMA request
    add(0,0,1,5'h1F,8'h3C, 1,0,5'h02,8'h00, 0,0,0,1,5'h1F,8'h3C, 0,8'h00,0);
    add(0,0,0,5'h00,8'h00, 1,0,5'h02,8'h00, 1,0,1,0,5'h02,8'h00, 0,8'h00,0);
    add(0,0,0,5'h00,8'h00, 1,0,5'h1F,8'h00, 1,0,1,0,5'h1F,8'h00, 1,8'h82,1);
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 1,8'h3C,1);
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 0,8'h00,0);
    // alternating CPU busy/idle, DMA reads 00..07 granted on each idle cycle
    for (int k = 0; k < 8; k++) begin
      add(0,1,0,5'h08,8'h00, 1,0,5'(k),8'h00, 0,0,1,0,5'h08,8'h00,
          (k > 0), (k > 0) ? memval(k - 1) : 8'h00, (k > 0));
      add(0,0,0,5'h00,8'h00, 1,0,5'(k),8'h00, 1,0,1,0,5'(k),8'h00, 0,8'h00,0);
    end
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 1,8'h87,1);
    // reset lands on a DMA write of EE -> 10; write must be dropped
    add(1,0,0,5'h00,8'h00, 1,1,5'h10,8'hEE, 0,0,0,0,5'h00,8'h00, 0,8'h00,0);
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 0,8'h00,1);
    add(0,0,0,5'h00,8'h00, 1,0,5'h10,8'h00, 1,0,1,0,5'h10,8'h00, 0,8'h00,0);
    add(0,0,0,5'h00,8'h00, 0,0,5'h00,8'h00, 0,0,0,0,5'h00,8'h00, 1,8'h11,1);

    @(negedge clk);
    mem_load = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].crd, vecs[i].cwr, vecs[i].ca, vecs[i].cwd,
            vecs[i].dreq, vecs[i].dwe, vecs[i].da, vecs[i].dw);
      chk($sformatf("v%0d dma_gnt", i),   32'(dma_gnt),   32'(vecs[i].gnt));
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d mem_rd", i),    32'(mem_rd),    32'(vecs[i].mrd));
      chk($sformatf("v%0d mem_wr", i),    32'(mem_wr),    32'(vecs[i].mwr));
      chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].ma));
      chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwd));
      chk($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].rv));
      if (vecs[i].rdchk)
        chk($sformatf("v%0d dma_rdata", i), 32'(dma_rdata), 32'(vecs[i].rd));
    end

    // early drop of dma_req must clear the starvation count and write nothing
    for (int e = 0; e < 2; e++) begin
      drive(0, 1,0,5'h08,8'h00, 1,1,5'h1E,8'h77);
      chk($sformatf("early%0d dma_gnt", e), 32'(dma_gnt), 32'd0);
      chk($sformatf("early%0d mem_wr", e),  32'(mem_wr),  32'd0);
    end
    drive(0, 1,0,5'h08,8'h00, 0,0,5'h00,8'h00);
    chk("drop dma_gnt", 32'(dma_gnt), 32'd0);
    for (int e = 0; e < 4; e++) begin
      drive(0, 1,0,5'h08,8'h00, 1,1,5'h1E,8'h77);
      chk($sformatf("reissue%0d dma_gnt", e), 32'(dma_gnt), 32'd0);
    end
    drive(0, 1,0,5'h08,8'h00, 1,1,5'h1E,8'h77);
    chk("forced dma_gnt",   32'(dma_gnt),   32'd1);
    chk("forced cpu_stall", 32'(cpu_stall), 32'd1);
    chk("forced mem_wr",    32'(mem_wr),    32'd1);
    chk("forced mem_addr",  32'(mem_addr),  32'h1E);
    chk("forced mem_wdata", 32'(mem_wdata), 32'h77);
    drive(0, 1,0,5'h08,8'h00, 0,0,5'h00,8'h00);
    chk("after force cpu_stall", 32'(cpu_stall), 32'd0);
    chk("after force mem_rd",    32'(mem_rd),    32'd1);
    chk("after force mem_addr",  32'(mem_addr),  32'h08);
    drive(0, 0,0,5'h00,8'h00, 1,0,5'h1E,8'h00);
    chk("readback 1E dma_gnt", 32'(dma_gnt), 32'd1);
    drive(0, 0,0,5'h00,8'h00, 0,0,5'h00,8'h00);
    chk("readback 1E dma_rvalid", 32'(dma_rvalid), 32'd1);
    chk("readback 1E dma_rdata",  32'(dma_rdata),  32'h77);

    // MAX_WAIT = 1: CPU and DMA saturated, slots alternate CPU/DMA
    drive(1, 0,0,5'h00,8'h00, 0,0,5'h00,8'h00);
    chk("mw1 reset dma_gnt", 32'(dma_gnt1), 32'd0);
    for (int c = 0; c < 8; c++) begin
      drive(0, 1,0,5'h08,8'h44, 1,1,5'h15,8'h99);
      chk($sformatf("mw1 c%0d dma_gnt", c),   32'(dma_gnt1),   32'(c % 2));
      chk($sformatf("mw1 c%0d cpu_stall", c), 32'(cpu_stall1), 32'(c % 2));
      chk($sformatf("mw1 c%0d mem_rd", c),    32'(mem_rd1),    32'((c + 1) % 2));
      chk($sformatf("mw1 c%0d mem_wr", c),    32'(mem_wr1),    32'(c % 2));
      chk($sformatf("mw1 c%0d mem_addr", c),  32'(mem_addr1),  (c % 2 == 1) ? 32'h15 : 32'h08);
      chk($sformatf("mw1 c%0d mem_wdata", c), 32'(mem_wdata1), (c % 2 == 1) ? 32'h99 : 32'h44);
      chk($sformatf("mw1 c%0d dma_rvalid", c), 32'(dma_rvalid1), 32'd0);
    end
    chk("mw1 dma_rdata", 32'(dma_rdata1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
